riscv_wb_arbiter: RTL and testbench
===================================

RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, entries per source FIFO (power of two, 2..8).
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 src_valid_i  input  4  per-source result valid; source k = 0..3 (ALU, MUL, DIV, LSU).
REQ-005 src_ready_o  output  4  per-source accept.
REQ-006 src_rd_i  input  4x5  per-source destination register index.
REQ-007 src_value_i  input  4x32  per-source result value.
REQ-008 rd0_o..rd3_o  output  5 each  register-file write indices, port k.
REQ-009 rd0_value_o..rd3_value_o  output  32 each  register-file write data, port k.
REQ-010 busy_o  output  32  bit r set while any write to register r is queued or on a write port.

Function
REQ-011 Source k SHALL have a private FIFO_DEPTH-entry FIFO holding {rd, value}; a transfer SHALL occur on any edge where src_valid_i[k] and src_ready_o[k] are both high.
REQ-012 src_ready_o[k] SHALL be high iff FIFO k occupancy < FIFO_DEPTH, from registered occupancy only; a full FIFO SHALL hold ready low during its issue cycle.
REQ-013 Entries with rd = 0 SHALL be accepted and then dropped at the FIFO head in the next cycle, without driving a write port.
REQ-014 Each cycle, the head of FIFO k with nonzero rd SHALL be a candidate for write port k only; no other source SHALL use port k.
REQ-015 Conflict rule: if two or more candidates share the same rd, only the lowest-index source SHALL issue; the others SHALL stay at their heads and retry on the next cycle.
REQ-016 An issued candidate SHALL be popped and loaded into port-k output registers on the same edge.
REQ-017 A port with no issue that cycle SHALL load rdk_o = 0 and rdk_value_o = 0.
REQ-018 Invariant: no two ports SHALL present the same nonzero rd in one cycle.
REQ-019 Invariant: all four ports SHALL present rd = 0 only when all carry value 0, so x0 stays zero.
REQ-020 Latency: an entry accepted at edge N into an empty FIFO, with no conflict, SHALL appear on its port from edge N+1 until edge N+2; the register file captures it at edge N+2.
REQ-021 Each source SHALL retire in FIFO order; no ordering SHALL be guaranteed between sources, and upstream uses busy_o to prevent WAW.
REQ-022 busy_o[r] SHALL be the OR of all valid FIFO entries and output registers with rd = r, for r != 0; busy_o[0] SHALL be 0.
REQ-023 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-024 While rst_i is high, all FIFOs SHALL empty, and all rdk_o, rdk_value_o, src_ready_o and busy_o SHALL be 0.
REQ-025 On the first edge after rst_i falls, src_ready_o SHALL be 4'b1111.
REQ-026 Reset during operation SHALL discard all queued and in-flight writes without emitting any further write.

Verification
REQ-027 Single write: source 0 pushes rd = 5, value 0x1234 at edge N -> rd0_o = 5, rd0_value_o = 0x1234 for one cycle starting at edge N+1; busy_o[5] = 1 from edge N until edge N+2.
REQ-028 Conflict: sources 1 and 3 push rd = 7 in the same cycle with values 0xA and 0xB -> port 1 carries 7/0xA first; port 3 carries 7/0xB one cycle later; port 3 carries 0/0 in the conflict cycle.
REQ-029 Full and backpressure: with FIFO_DEPTH = 2, source 2 pushes 3 entries while another source's head holds the same rd -> src_ready_o[2] drops after 2 accepts; the 3rd entry is accepted only after a pop; output order is preserved.
REQ-030 x0 drop: source 0 pushes rd = 0, value 0xFFFF -> all ports stay 0/0; busy_o = 0.
REQ-031 All four sources push distinct rd = 1..4 in the same cycle -> all four ports write in one cycle; next cycle all ports are 0/0.
REQ-032 Reset mid-stream: assert rst_i with entries in 3 FIFOs -> all outputs are 0 immediately; after release no stale write appears and src_ready_o = 4'b1111.

Source files
------------

// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter: four per-source result FIFOs feeding four register-file write ports,
// with same-rd conflicts resolved in favour of the lowest source index.
module riscv_wb_arbiter #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [3:0]   src_valid_i,
    output logic [3:0]   src_ready_o,
    input  logic [19:0]  src_rd_i,
    input  logic [127:0] src_value_i,
    output logic [4:0]   rd0_o,
    output logic [4:0]   rd1_o,
    output logic [4:0]   rd2_o,
    output logic [4:0]   rd3_o,
    output logic [31:0]  rd0_value_o,
    output logic [31:0]  rd1_value_o,
    output logic [31:0]  rd2_value_o,
    output logic [31:0]  rd3_value_o,
    output logic [31:0]  busy_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [4:0]       r_fifo_rd  [4][FIFO_DEPTH];
    logic [31:0]      r_fifo_val [4][FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr     [4];
    logic [PTR_W-1:0] r_rptr     [4];
    logic [CNT_W-1:0] r_count    [4];
    logic [4:0]       r_out_rd   [4];
    logic [31:0]      r_out_val  [4];

    logic [4:0]  w_head_rd  [4];
    logic [31:0] w_head_val [4];
    logic [3:0]  w_head_vld;
    logic [3:0]  w_cand;
    logic [3:0]  w_issue;
    logic [3:0]  w_pop;
    logic [3:0]  w_push;
    logic [31:0] w_busy;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_head_rd[k]  = r_fifo_rd[k][r_rptr[k]];
            w_head_val[k] = r_fifo_val[k][r_rptr[k]];
            w_head_vld[k] = (r_count[k] != '0);
            w_cand[k]     = w_head_vld[k] && (w_head_rd[k] != 5'd0);
            src_ready_o[k] = !rst_i && (r_count[k] < CNT_W'(FIFO_DEPTH));
            w_push[k]     = src_valid_i[k] && src_ready_o[k];
        end
    end

    // A candidate loses to any lower-index candidate targeting the same rd.
    always_comb begin
        w_issue = '0;
        w_pop   = '0;
        for (int k = 0; k < 4; k++) begin
            w_issue[k] = w_cand[k];
            for (int j = 0; j < k; j++) begin
                if (w_cand[j] && (w_head_rd[j] == w_head_rd[k])) begin
                    w_issue[k] = 1'b0;
                end
            end
            // rd = 0 entries are discarded at the head without using the port.
            w_pop[k] = w_issue[k] || (w_head_vld[k] && !w_cand[k]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < 4; k++) begin
                r_wptr[k]    <= '0;
                r_rptr[k]    <= '0;
                r_count[k]   <= '0;
                r_out_rd[k]  <= '0;
                r_out_val[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (w_push[k]) begin
                    r_wptr[k] <= r_wptr[k] + PTR_W'(1);
                end
                if (w_pop[k]) begin
                    r_rptr[k] <= r_rptr[k] + PTR_W'(1);
                end
                if (w_push[k] && !w_pop[k]) begin
                    r_count[k] <= r_count[k] + CNT_W'(1);
                end else if (!w_push[k] && w_pop[k]) begin
                    r_count[k] <= r_count[k] - CNT_W'(1);
                end
                r_out_rd[k]  <= w_issue[k] ? w_head_rd[k]  : 5'd0;
                r_out_val[k] <= w_issue[k] ? w_head_val[k] : 32'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (w_push[k]) begin
                r_fifo_rd[k][r_wptr[k]]  <= src_rd_i[5*k +: 5];
                r_fifo_val[k][r_wptr[k]] <= src_value_i[32*k +: 32];
            end
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        w_busy = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CNT_W'(PTR_W'(PTR_W'(i) - r_rptr[k])) < r_count[k]) begin
                    w_busy[r_fifo_rd[k][i]] = 1'b1;
                end
            end
            w_busy[r_out_rd[k]] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign busy_o      = w_busy;
    assign rd0_o       = r_out_rd[0];
    assign rd1_o       = r_out_rd[1];
    assign rd2_o       = r_out_rd[2];
    assign rd3_o       = r_out_rd[3];
    assign rd0_value_o = r_out_val[0];
    assign rd1_value_o = r_out_val[1];
    assign rd2_value_o = r_out_val[2];
    assign rd3_value_o = r_out_val[3];

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Bench for riscv_wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_riscv_wb_arbiter;

    localparam int unsigned D = 2;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic [3:0]   src_valid_i;
    logic [3:0]   src_ready_o;
    logic [19:0]  src_rd_i;
    logic [127:0] src_value_i;
    logic [4:0]   rd0_o, rd1_o, rd2_o, rd3_o;
    logic [31:0]  rd0_value_o, rd1_value_o, rd2_value_o, rd3_value_o;
    logic [31:0]  busy_o;

    always #5 clk_i = ~clk_i;

    riscv_wb_arbiter #(.FIFO_DEPTH(D)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_rd_i    (src_rd_i),
        .src_value_i (src_value_i),
        .rd0_o       (rd0_o),
        .rd1_o       (rd1_o),
        .rd2_o       (rd2_o),
        .rd3_o       (rd3_o),
        .rd0_value_o (rd0_value_o),
        .rd1_value_o (rd1_value_o),
        .rd2_value_o (rd2_value_o),
        .rd3_value_o (rd3_value_o),
        .busy_o      (busy_o)
    );

    logic [4:0]  d_rd  [4];
    logic [31:0] d_val [4];
    assign d_rd[0] = rd0_o;  assign d_val[0] = rd0_value_o;
    assign d_rd[1] = rd1_o;  assign d_val[1] = rd1_value_o;
    assign d_rd[2] = rd2_o;  assign d_val[2] = rd2_value_o;
    assign d_rd[3] = rd3_o;  assign d_val[3] = rd3_value_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } ent_t;

    ent_t        mq [4][$];
    logic [4:0]  exp_rd  [4];
    logic [31:0] exp_val [4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) begin
            mq[k].delete();
            exp_rd[k]  = '0;
            exp_val[k] = '0;
        end
    endtask

    // One clock edge of the model: drop rd=0 heads, grant each rd to the first claimant, then accept.
    task automatic model_step();
        logic [3:0]  acc;
        logic [31:0] claimed;
        ent_t        h;
        if (rst_i) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 4; k++) acc[k] = src_valid_i[k] && (mq[k].size() < D);
        claimed = '0;
        for (int k = 0; k < 4; k++) begin
            exp_rd[k]  = '0;
            exp_val[k] = '0;
            if (mq[k].size() > 0) begin
                h = mq[k][0];
                if (h.rd == 5'd0) begin
                    void'(mq[k].pop_front());
                end else if (!claimed[h.rd]) begin
                    claimed[h.rd] = 1'b1;
                    exp_rd[k]     = h.rd;
                    exp_val[k]    = h.val;
                    void'(mq[k].pop_front());
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (acc[k]) begin
                h.rd  = src_rd_i[5*k +: 5];
                h.val = src_value_i[32*k +: 32];
                mq[k].push_back(h);
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] eb;
        logic [3:0]  er;
        eb = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < mq[k].size(); i++) eb[mq[k][i].rd] = 1'b1;
            eb[exp_rd[k]] = 1'b1;
            er[k] = !rst_i && (mq[k].size() < D);
        end
        eb[0] = 1'b0;
        check("ready", 32'(src_ready_o), 32'(er));
        check("busy", busy_o, eb);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("port%0d_rd", k), 32'(d_rd[k]), 32'(exp_rd[k]));
            check($sformatf("port%0d_value", k), d_val[k], exp_val[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        model_step();
        compare_all();
    endtask

    task automatic drive(input int k, input logic [4:0] rd, input logic [31:0] val);
        src_valid_i[k]          = 1'b1;
        src_rd_i[5*k +: 5]      = rd;
        src_value_i[32*k +: 32] = val;
    endtask

    task automatic idle(input int n);
        src_valid_i = '0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        src_valid_i = '0;
        src_rd_i    = '0;
        src_value_i = '0;
        model_clear();
        #2;
        compare_all();
        check("reset_ready", 32'(src_ready_o), 32'h0);
        check("reset_busy", busy_o, 32'h0);
        tick();
        tick();
        #2 rst_i = 1'b0;
        tick();
        check("first_edge_ready", 32'(src_ready_o), 32'hF);

        // Single write.
        drive(0, 5'd5, 32'h1234);
        tick();
        check("single_busy_queued", 32'(busy_o[5]), 32'h1);
        check("single_not_yet", 32'(rd0_o), 32'h0);
        src_valid_i = '0;
        tick();
        check("single_rd", 32'(rd0_o), 32'h5);
        check("single_val", rd0_value_o, 32'h1234);
        check("single_busy_port", 32'(busy_o[5]), 32'h1);
        tick();
        check("single_rd_clear", 32'(rd0_o), 32'h0);
        check("single_busy_clear", 32'(busy_o[5]), 32'h0);
        idle(1);

        // Conflict between sources 1 and 3.
        drive(1, 5'd7, 32'hA);
        drive(3, 5'd7, 32'hB);
        tick();
        src_valid_i = '0;
        tick();
        check("conf_p1_rd", 32'(rd1_o), 32'h7);
        check("conf_p1_val", rd1_value_o, 32'hA);
        check("conf_p3_rd_idle", 32'(rd3_o), 32'h0);
        check("conf_p3_val_idle", rd3_value_o, 32'h0);
        tick();
        check("conf_p3_rd", 32'(rd3_o), 32'h7);
        check("conf_p3_val", rd3_value_o, 32'hB);
        check("conf_p1_clear", 32'(rd1_o), 32'h0);
        idle(2);

        // Backpressure: source 0 keeps rd 9 busy so source 2 stalls and fills.
        drive(0, 5'd9, 32'h90);
        drive(2, 5'd9, 32'hE1);
        tick();
        check("bp_ready_1", 32'(src_ready_o[2]), 32'h1);
        src_value_i[64 +: 32] = 32'hE2;
        tick();
        check("bp_ready_full", 32'(src_ready_o[2]), 32'h0);
        src_value_i[64 +: 32] = 32'hE3;
        tick();
        check("bp_ready_held", 32'(src_ready_o[2]), 32'h0);
        tick();
        src_valid_i[0] = 1'b0;
        tick();
        check("bp_p0_rd", 32'(rd0_o), 32'h9);
        check("bp_p2_stalled", 32'(rd2_o), 32'h0);
        tick();
        check("bp_e1", rd2_value_o, 32'hE1);
        check("bp_ready_after_pop", 32'(src_ready_o[2]), 32'h1);
        tick();
        check("bp_e2", rd2_value_o, 32'hE2);
        src_valid_i = '0;
        tick();
        check("bp_e3", rd2_value_o, 32'hE3);
        check("bp_e3_rd", 32'(rd2_o), 32'h9);
        idle(2);

        // rd = 0 is accepted and dropped.
        drive(0, 5'd0, 32'hFFFF);
        tick();
        check("x0_busy", busy_o, 32'h0);
        src_valid_i = '0;
        tick();
        check("x0_rd", 32'(rd0_o), 32'h0);
        check("x0_val", rd0_value_o, 32'h0);
        idle(1);

        // Four distinct writes in one cycle.
        for (int k = 0; k < 4; k++) drive(k, 5'(k + 1), 32'h100 + 32'(k));
        tick();
        src_valid_i = '0;
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("all4_rd%0d", k), 32'(d_rd[k]), 32'(k + 1));
            check($sformatf("all4_val%0d", k), d_val[k], 32'h100 + 32'(k));
        end
        tick();
        for (int k = 0; k < 4; k++) check($sformatf("all4_clear%0d", k), 32'(d_rd[k]), 32'h0);
        idle(1);

        // Reset with three FIFOs holding entries.
        for (int k = 0; k < 3; k++) drive(k, 5'(k + 10), 32'hC0 + 32'(k));
        tick();
        src_valid_i = '0;
        #2 rst_i = 1'b1;
        #1;
        model_clear();
        compare_all();
        check("rst_mid_busy", busy_o, 32'h0);
        check("rst_mid_ready", 32'(src_ready_o), 32'h0);
        tick();
        tick();
        #2 rst_i = 1'b0;
        #1;
        check("rst_rel_ready", 32'(src_ready_o), 32'hF);
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int k = 0; k < 4; k++) check("rst_no_stale", 32'(d_rd[k]), 32'h0);
        end

        // Randomized traffic with small rd range to provoke conflicts and rd = 0.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 4; k++) begin
                src_valid_i[k] = ($urandom_range(0, 9) < 6);
                src_rd_i[5*k +: 5] = 5'($urandom_range(0, 7));
                src_value_i[32*k +: 32] = $urandom;
            end
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_i = 1'b1;
                #1;
                model_clear();
                compare_all();
                tick();
                #2 rst_i = 1'b0;
            end else begin
                tick();
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
